// File: rtl/johnson_pkg.sv
// johnson_pkg: shared Johnson code constants and decoder FSM states.
// Used by the counter, the code LUT and the decoder top.
package johnson_pkg;

    localparam logic [3:0] S0 = 4'b0000;
    localparam logic [3:0] S1 = 4'b0001;
    localparam logic [3:0] S2 = 4'b0011;
    localparam logic [3:0] S3 = 4'b0111;
    localparam logic [3:0] S4 = 4'b1111;
    localparam logic [3:0] S5 = 4'b1110;
    localparam logic [3:0] S6 = 4'b1100;
    localparam logic [3:0] S7 = 4'b1000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: code stream in, decode/lock/error results out.
// master = stream source/observer, slave = decoder.
interface johnson_decoder_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [3:0]       code;
    logic             err_clr;
    logic [2:0]       idx;
    logic             idx_valid;
    logic             locked;
    logic             illegal;
    logic             seq_err;
    logic             wrap;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, code, err_clr,
        input  idx, idx_valid, locked, illegal,
        input  seq_err, wrap, err_count
    );

    modport slave (
        input  in_valid, code, err_clr,
        output idx, idx_valid, locked, illegal,
        output seq_err, wrap, err_count
    );
endinterface

// File: rtl/johnson_lut.sv
// johnson_lut: combinational Johnson code -> index map with legality flag.
// Ports: code_i (4b code), idx_o (3b index), legal_o (code is one of 8).
module johnson_lut
    import johnson_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [2:0] idx_o,
    output logic       legal_o
);
    always_comb begin
        idx_o   = 3'd0;
        legal_o = 1'b1;
        unique case (code_i)
            S0:      idx_o = 3'd0;
            S1:      idx_o = 3'd1;
            S2:      idx_o = 3'd2;
            S3:      idx_o = 3'd3;
            S4:      idx_o = 3'd4;
            S5:      idx_o = 3'd5;
            S6:      idx_o = 3'd6;
            S7:      idx_o = 3'd7;
            default: legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a Johnson code stream, tracks sequence lock.
// Ports: clk, rst (async active-low), bus (slave: stream + results).
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input logic              clk,
    input logic              rst,
    johnson_decoder_if.slave bus
);
    state_t           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       run_q, run_d;
    logic [2:0]       idx_q, idx_d;
    logic             idv_q, idv_d;
    logic             lock_q, lock_d;
    logic             ill_q, ill_d;
    logic             seq_q, seq_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [2:0] lut_idx;
    logic       lut_legal;
    logic       hit;
    logic [2:0] run_inc;
    logic       err_evt;

    johnson_lut u_lut (
        .code_i  (bus.code),
        .idx_o   (lut_idx),
        .legal_o (lut_legal)
    );

    assign hit     = (lut_idx == exp_q);
    assign run_inc = run_q + 3'd1;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        idx_d   = idx_q;
        idv_d   = 1'b0;
        ill_d   = 1'b0;
        seq_d   = 1'b0;
        wrap_d  = 1'b0;
        if (bus.in_valid) begin
            if (!lut_legal) begin
                ill_d   = 1'b1;
                state_d = HUNT;
                run_d   = 3'd0;
            end else begin
                idx_d = lut_idx;
                idv_d = 1'b1;
                exp_d = lut_idx + 3'd1;
                unique case (state_q)
                    HUNT: begin
                        state_d = ACQ;
                        run_d   = 3'd0;
                    end
                    ACQ: begin
                        if (hit) begin
                            run_d = run_inc;
                            if (run_inc == 3'(LOCK_CNT))
                                state_d = LOCKED;
                        end else begin
                            run_d = 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            // a correct successor of index 0 means 7 -> 0
                            wrap_d = (lut_idx == 3'd0);
                        end else begin
                            seq_d   = 1'b1;
                            state_d = ACQ;
                            run_d   = 3'd0;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        run_d   = 3'd0;
                    end
                endcase
            end
        end
    end

    assign lock_d  = (state_d == LOCKED);
    assign err_evt = ill_d | seq_d;

    // clear wins, but an event in the same cycle is still counted
    always_comb begin
        err_d = err_q;
        if (bus.err_clr)
            err_d = {{(ERR_W-1){1'b0}}, err_evt};
        else if (err_evt && !(&err_q))
            err_d = err_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HUNT;
            exp_q   <= 3'd0;
            run_q   <= 3'd0;
            idx_q   <= 3'd0;
            idv_q   <= 1'b0;
            lock_q  <= 1'b0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            idx_q   <= idx_d;
            idv_q   <= idv_d;
            lock_q  <= lock_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idv_q;
    assign bus.locked    = lock_q;
    assign bus.illegal   = ill_q;
    assign bus.seq_err   = seq_q;
    assign bus.wrap      = wrap_q;
    assign bus.err_count = err_q;
endmodule
